mult_div_unit: RTL and testbench

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mult_div_unit.sv | 183 ++++++++++++++++++
 tb/tb_mult_div_unit.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// mult_div_unit: multi-cycle multiply/divide unit with architectural HI/LO.
//
// The full result is computed combinationally when the operation is issued
// and held in shadow registers. A down-counter then models the busy latency,
// and the shadow result is copied to hi/lo on the final busy edge.
//
// States:
//   state  | meaning
//   -------+------------------------------------------------------------
//   S_IDLE | ready; accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO on start
//   S_BUSY | counting down the busy cycles; start ignored; commit at 1
//
// Ports:
//   clk    in   rising-edge clock
//   reset  in   synchronous active-high reset
//   start  in   issue strobe for op
//   op     in   0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 no-op
//   src_a  in   multiplicand / dividend / MT data
//   src_b  in   multiplier / divisor
//   busy   out  unit is computing
//   done   out  one-cycle pulse when hi/lo first show a new mult/div result
//   hi     out  architectural HI register
//   lo     out  architectural LO register
module mult_div_unit #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  localparam logic [CW-1:0]    MULT_LOAD = CW'(MULT_CYCLES);
  localparam logic [CW-1:0]    DIV_LOAD  = CW'(DIV_CYCLES);
  localparam logic [CW-1:0]    CNT_ONE   = CW'(1);
  localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t             r_state;
  logic [CW-1:0]      r_count;
  logic               r_busy;
  logic               r_done;
  logic               r_div0;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic [WIDTH-1:0]   r_shadow_hi;
  logic [WIDTH-1:0]   r_shadow_lo;

  logic               w_signed_div;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [WIDTH-1:0]   w_dvd;
  logic [WIDTH-1:0]   w_dvs;
  logic [WIDTH-1:0]   w_q_u;
  logic [WIDTH-1:0]   w_r_u;
  logic [WIDTH-1:0]   w_quot;
  logic [WIDTH-1:0]   w_rem;
  logic [2*WIDTH-1:0] w_ext_a;
  logic [2*WIDTH-1:0] w_ext_b;
  logic [2*WIDTH-1:0] w_prod;

  // Signed division runs on magnitudes and fixes signs afterwards. The
  // overflow case (most-negative / -1) falls out naturally: the magnitude
  // quotient 2^(WIDTH-1) is not negated and reads back as -2^(WIDTH-1).
  // A zero divisor is swapped for 1 so the divider never sees x/0; the
  // result is discarded at commit anyway.
  always_comb begin
    w_signed_div = (op == OP_DIV);
    w_a_neg      = src_a[WIDTH-1];
    w_b_neg      = src_b[WIDTH-1];
    w_a_mag      = w_a_neg ? (~src_a + ONE) : src_a;
    w_b_mag      = w_b_neg ? (~src_b + ONE) : src_b;
    w_dvd        = w_signed_div ? w_a_mag : src_a;
    w_dvs        = w_signed_div ? w_b_mag : src_b;
    if (src_b == '0) begin
      w_dvs = ONE;
    end
    w_q_u  = w_dvd / w_dvs;
    w_r_u  = w_dvd % w_dvs;
    w_quot = (w_signed_div && (w_a_neg ^ w_b_neg)) ? (~w_q_u + ONE) : w_q_u;
    w_rem  = (w_signed_div && w_a_neg) ? (~w_r_u + ONE) : w_r_u;

    if (op == OP_MULT) begin
      w_ext_a = {{WIDTH{src_a[WIDTH-1]}}, src_a};
      w_ext_b = {{WIDTH{src_b[WIDTH-1]}}, src_b};
    end else begin
      w_ext_a = {{WIDTH{1'b0}}, src_a};
      w_ext_b = {{WIDTH{1'b0}}, src_b};
    end
    // Truncating the sign-extended product to 2*WIDTH gives the signed result.
    w_prod = w_ext_a * w_ext_b;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_count     <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_div0      <= 1'b0;
      r_hi        <= '0;
      r_lo        <= '0;
      r_shadow_hi <= '0;
      r_shadow_lo <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            case (op)
              OP_MULT, OP_MULTU: begin
                r_shadow_hi <= w_prod[2*WIDTH-1:WIDTH];
                r_shadow_lo <= w_prod[WIDTH-1:0];
                r_div0      <= 1'b0;
                r_count     <= MULT_LOAD;
                r_busy      <= 1'b1;
                r_state     <= S_BUSY;
              end
              OP_DIV, OP_DIVU: begin
                r_shadow_hi <= w_rem;
                r_shadow_lo <= w_quot;
                r_div0      <= (src_b == '0);
                r_count     <= DIV_LOAD;
                r_busy      <= 1'b1;
                r_state     <= S_BUSY;
              end
              OP_MTHI: r_hi <= src_a;
              OP_MTLO: r_lo <= src_a;
              default: ;
            endcase
          end
        end
        S_BUSY: begin
          if (r_count == CNT_ONE) begin
            if (!r_div0) begin
              r_hi <= r_shadow_hi;
              r_lo <= r_shadow_lo;
            end
            r_count <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_count <= r_count - CNT_ONE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_count <= '0;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: scoreboard bench for mult_div_unit (WIDTH=32, 5/10 cycles).
// Stimulus pushes the expected hi/lo/busy-length of each accepted mult/div
// into a queue; a negedge monitor pops and compares whenever done pulses.
module tb_mult_div_unit;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  mult_div_unit #(.WIDTH(32), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .src_a (src_a),
    .src_b (src_b),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          n;
  } exp_t;

  exp_t        sb[$];
  int          checks     = 0;
  int          failures   = 0;
  int          done_count = 0;
  int          busy_run   = 0;
  logic        prev_done  = 1'b0;
  logic [31:0] model_hi   = '0;
  logic [31:0] model_lo   = '0;
  logic [31:0] pend_hi    = '0;
  logic [31:0] pend_lo    = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain arithmetic on 64-bit / 32-bit integers.
  function automatic logic [63:0] ref_op(input logic [2:0] o, input logic [31:0] a,
                                         input logic [31:0] b, input logic [31:0] ch,
                                         input logic [31:0] cl);
    longint      sa, sbv;
    logic [63:0] p;
    logic [31:0] q, r;
    case (o)
      3'd0: begin
        sa  = $signed(a);
        sbv = $signed(b);
        p   = sa * sbv;
        return p;
      end
      3'd1: begin
        p = {32'd0, a} * {32'd0, b};
        return p;
      end
      3'd2: begin
        if (b == 0) return {ch, cl};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
        return {r, q};
      end
      default: begin
        if (b == 0) return {ch, cl};
        q = a / b;
        r = a % b;
        return {r, q};
      end
    endcase
  endfunction

  // Monitor: sole consumer of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      busy_run = 0;
    end else begin
      if (done) begin
        done_count++;
        check("done_pulse_width", {31'd0, prev_done}, 32'd0);
        check("busy_in_done_cycle", {31'd0, busy}, 32'd0);
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done actual=done expected=no_done at %0t", $time);
        end else begin
          e = sb.pop_front();
          check("result_hi", hi, e.hi);
          check("result_lo", lo, e.lo);
          check("busy_cycles", busy_run, e.n);
        end
        busy_run = 0;
      end
      if (busy) busy_run++;
    end
    prev_done = done;
  end

  // Called at a negedge. accepted: unit is idle so the op takes effect.
  // track: push the expected result (cleared only for the reset-abort case).
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input bit accepted, input bit track);
    logic [63:0] r;
    exp_t e;
    op    = o;
    src_a = a;
    src_b = b;
    start = 1'b1;
    if (accepted && track && o <= 3'd3) begin
      r    = ref_op(o, a, b, model_hi, model_lo);
      e.hi = r[63:32];
      e.lo = r[31:0];
      e.n  = (o <= 3'd1) ? MC : DC;
      sb.push_back(e);
      pend_hi = e.hi;
      pend_lo = e.lo;
    end
    @(negedge clk);
    start = 1'b0;
    op    = 3'd6;
    if (accepted && o == 3'd4) model_hi = a;
    if (accepted && o == 3'd5) model_lo = a;
    if (accepted && o <= 3'd3) begin
      check("busy_after_issue", {31'd0, busy}, 32'd1);
    end else begin
      check("busy_level", {31'd0, busy}, accepted ? 32'd0 : 32'd1);
      check("hi_hold", hi, model_hi);
      check("lo_hold", lo, model_lo);
    end
  endtask

  // remaining: negedges expected from now until the done cycle.
  task automatic wait_done(input int remaining);
    int  cnt = 0;
    bit  got = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      cnt++;
      if (done) begin
        got = 1;
        break;
      end
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL done_timeout actual=no_done expected=done at %0t", $time);
    end else begin
      check("latency", cnt, remaining);
    end
    model_hi = pend_hi;
    model_lo = pend_lo;
  endtask

  initial begin
    logic [2:0]  ro;
    logic [31:0] ra, rb;
    int          extra;
    int          dc_before;

    reset = 1'b1;
    start = 1'b0;
    op    = 3'd6;
    src_a = '0;
    src_b = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Directed vectors, back-to-back where possible.
    issue(3'd0, 32'hFFFF_FFFD, 32'd7, 1, 1);
    wait_done(MC);
    issue(3'd1, 32'hFFFF_FFFF, 32'd2, 1, 1);
    wait_done(MC);
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1, 1);
    wait_done(DC);
    issue(3'd2, 32'hFFFF_FFF9, 32'd2, 1, 1);
    wait_done(DC);
    issue(3'd3, 32'd7, 32'd2, 1, 1);
    wait_done(DC);
    @(negedge clk);
    check("done_low_after_pulse", {31'd0, done}, 32'd0);

    issue(3'd4, 32'h1234_5678, 32'd0, 1, 1);
    issue(3'd3, 32'd99, 32'd0, 1, 1);
    wait_done(DC);
    check("div0_hi_kept", hi, 32'h1234_5678);

    issue(3'd0, 32'd3, 32'd4, 1, 1);
    issue(3'd5, 32'h0000_AAAA, 32'd0, 0, 1);
    issue(3'd0, 32'd9, 32'd9, 0, 1);
    wait_done(MC - 2);
    check("ignored_lo", lo, 32'd12);

    issue(3'd7, 32'hDEAD_BEEF, 32'd1, 1, 1);

    // Reset aborts an in-flight DIV during its third busy cycle.
    issue(3'd2, 32'd100, 32'd3, 1, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_hi = '0;
    model_lo = '0;
    pend_hi  = '0;
    pend_lo  = '0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_hi", hi, 32'd0);
    check("abort_lo", lo, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    dc_before = done_count;
    repeat (20) @(negedge clk);
    check("abort_no_done", done_count, dc_before);

    // Randomized traffic.
    for (int it = 0; it < 80; it++) begin
      ro = 3'($urandom_range(0, 7));
      ra = $urandom();
      rb = $urandom();
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 9));
        2: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        3: ra = 32'($urandom_range(0, 100));
        default: ;
      endcase
      issue(ro, ra, rb, 1, 1);
      if (ro <= 3'd3) begin
        extra = $urandom_range(0, 2);
        for (int k = 0; k < extra; k++) begin
          issue(3'($urandom_range(0, 7)), $urandom(), $urandom(), 0, 1);
        end
        wait_done(((ro <= 3'd1) ? MC : DC) - extra);
        if ($urandom_range(0, 1) == 1) @(negedge clk);
      end
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
